// File: rtl/spi_slave.sv
// SPI mode-0 target running on mclk. sclk, cs_n and mosi are oversampled
// through synchronizers; edges are detected in the mclk domain. Received words
// leave on a valid/ready port, transmit words enter a one-deep holding buffer.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LSB_FIRST   = 1
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  underrun
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [CW-1:0]          count;
    logic [DATA_WIDTH-1:0]  rx_shift, rx_next;
    logic [DATA_WIDTH-1:0]  tx_shift, tx_shifted, load_word;
    logic [DATA_WIDTH-1:0]  hold_data;
    logic                   hold_full;
    logic                   load_first_bit, next_bit;

    logic                   start, stop, sample, shift, load, complete, accept;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    assign tx_ready  = ~hold_full;
    assign accept    = tx_valid & ~hold_full;
    assign busy      = (state_q == SHIFT);

    // Synchronizer chains plus one extra copy for edge detection.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    // Frame state register.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle strobes; a cs_n rising edge masks sclk edges.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        stop    = 1'b0;
        sample  = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    stop    = 1'b1;
                end else begin
                    sample = sclk_rise;
                    shift  = sclk_fall;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift-register datapath helpers, selected by bit order.
    always_comb begin
        load      = start | (shift & (count == '0));
        complete  = sample & (count == LAST_BIT);
        load_word = hold_full ? hold_data : '0;
        if (LSB_FIRST != 0) begin
            rx_next        = {mosi_s, rx_shift[DATA_WIDTH-1:1]};
            tx_shifted     = tx_shift >> 1;
            next_bit       = tx_shift[1];
            load_first_bit = load_word[0];
        end else begin
            rx_next        = {rx_shift[DATA_WIDTH-2:0], mosi_s};
            tx_shifted     = tx_shift << 1;
            next_bit       = tx_shift[DATA_WIDTH-2];
            load_first_bit = load_word[DATA_WIDTH-1];
        end
    end

    // Transmit side: holding buffer, shift register, miso and underrun.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            tx_shift  <= '0;
            miso      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (accept) begin
                hold_data <= tx_data;
            end
            // An accept in the same cycle as a load keeps the new word.
            if (accept) begin
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (load) begin
                tx_shift <= load_word;
                miso     <= load_first_bit;
                underrun <= ~hold_full;
            end else if (shift) begin
                tx_shift <= tx_shifted;
                miso     <= next_bit;
            end else if (stop) begin
                miso <= 1'b0;
            end
        end
    end

    // Receive side: bit counter, assembly register, output word and overrun.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (start || stop) begin
                count <= '0;
            end else if (sample) begin
                count <= (count == LAST_BIT) ? '0 : count + 1'b1;
            end
            if (sample) begin
                rx_shift <= rx_next;
            end
            // A new word beats a simultaneous read; overrun only if unread and not taken.
            if (complete) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                overrun  <= rx_valid & ~rx_ready;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 target (CPOL=0, CPHA=0) running on the system clock `mclk`; it is the responder end of the team's SPI master link.
- External `sclk`, `cs_n` and `mosi` are oversampled through synchronizers, and their edges are detected in the `mclk` domain.
- Received words are delivered on a valid/ready parallel port; transmit words are accepted into a one-deep holding buffer.
- Bit order is LSB-first by default, to interoperate with the team's master.

Parameters:
- DATA_WIDTH, 8: bits per SPI word.
- SYNC_STAGES, 2: synchronizer depth on `sclk`, `cs_n` and `mosi` (legal values 2..3).
- LSB_FIRST, 1: 1 = bit 0 is shifted first; 0 = MSB is shifted first.

Ports:
- mclk  input  1  system clock; must run at least 4x the `sclk` frequency.
- reset  input  1  asynchronous reset, active-low.
- sclk  input  1  SPI clock from the master; asynchronous to `mclk`.
- cs_n  input  1  chip select, active-low; asynchronous.
- mosi  input  1  serial data from the master.
- miso  output  1  serial data to the master.
- tx_data  input  DATA_WIDTH  word to transmit.
- tx_valid  input  1  `tx_data` is valid.
- tx_ready  output  1  holding buffer is empty; transfer occurs when `tx_valid && tx_ready`.
- rx_data  output  DATA_WIDTH  last received word.
- rx_valid  output  1  `rx_data` is unread.
- rx_ready  input  1  consumer accepts `rx_data`.
- busy  output  1  a frame is in progress (`cs_n` asserted, after synchronization).
- overrun  output  1  one-cycle pulse: a word completed while `rx_valid` was still 1.
- underrun  output  1  one-cycle pulse: a word load found the holding buffer empty.

Behaviour:
- Clock and reset:
  - Single clock `mclk`; reset is asynchronous and active-low.
  - Reset values: `miso`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `busy`=0, `overrun`=0, `underrun`=0.
  - Internal reset values: bit counter=0, shift registers=0, holding buffer empty, synchronizers reset to `sclk`=0, `cs_n`=1, `mosi`=0.
- Synchronization and edge detection:
  - Each input passes through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchronizer stage with one extra registered copy.
  - Action latency is SYNC_STAGES+1 `mclk` cycles from a pin edge.
- State machine, IDLE -> SHIFT:
  - IDLE: `miso`=0, `busy`=0.
  - On a synchronized `cs_n` falling edge: go to SHIFT, `busy`=1, counter=0.
  - On that same `cs_n` falling edge, the transmit shift register loads from the holding buffer, or loads 0 with an `underrun` pulse if the buffer is empty.
  - `miso` drives the first bit (bit 0 if LSB_FIRST, else bit DATA_WIDTH-1) in that same cycle.
- SHIFT, on a synchronized `sclk` rising edge:
  - Sample synchronized `mosi` into the receive shift register.
  - Increment the counter.
- Word completion:
  - When the sample just taken is bit DATA_WIDTH-1, the assembled word goes to `rx_data` and `rx_valid`=1.
  - If `rx_valid` was already 1 and `rx_ready`=0 in that cycle, `rx_data` is overwritten and `overrun` pulses.
  - The counter wraps to 0.
- SHIFT, on a synchronized `sclk` falling edge:
  - If counter≠0: shift the transmit register and drive the next bit on `miso`.
  - If counter=0 (word boundary, continuous frame): reload from the holding buffer (or 0 with `underrun`) and drive its first bit.
- Receive handshake:
  - `rx_valid` clears on `rx_valid && rx_ready`.
  - If a clear and a new completion happen in the same cycle, the new word wins: `rx_valid` stays 1 and there is no `overrun`.
- Transmit handshake:
  - Accepting a word sets the holding buffer full and `tx_ready`=0.
  - A load into the shift register empties the buffer.
  - If a load and an accept happen in the same cycle, the new word is stored and `tx_ready`=0.
- Frame end or abort:
  - A synchronized `cs_n` rising edge at any point forces IDLE.
  - A partial word is discarded: no `rx_valid`, counter=0, `miso`=0.
  - An unconsumed holding-buffer word is retained.
- `sclk` edges while in IDLE are ignored.
- Assertion of `reset` mid-frame returns everything to reset values immediately.

Test Plan:
1. Reset, preload `tx_data`=0xA5, then the master sends 0x3C LSB-first in one frame -> `rx_data`=0x3C with `rx_valid`=1; the master receives 0xA5; `tx_ready` returns to 1 after the load.
2. Two-word frame: preload 0x11, refill 0x22 while the first word is shifting; the master sends 0x81 then 0x7E -> `rx_valid` pulses twice with 0x81 then 0x7E; the master receives 0x11 then 0x22; `underrun` never asserts.
3. Empty holding buffer at `cs_n` assertion -> `underrun` pulses once; the master receives 0x00; `rx_data` is still correct.
4. `rx_ready` held 0 across two received words 0x55 and 0xAA -> `overrun` pulses at the second completion; `rx_data`=0xAA.
5. `cs_n` deasserted after 5 bits -> no `rx_valid`; `busy`=0; `miso`=0; the next full frame of 0xF0 is received correctly.
6. `reset` asserted mid-word after 3 bits -> all outputs take reset values; after release, a frame of 0x96 with preload 0x69 exchanges correctly (LSB_FIRST=0 variant: the same values, MSB first).
